// File: rtl/ifetch_axi_master_pkg.sv
// Shared definitions for the instruction-fetch AXI read initiator:
// response codes, burst limit and the fetch FSM state encoding.
package ifetch_axi_master_pkg;

  localparam int AXI_RMAX_BEATS = 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } ifetch_axi_state_t;

endpackage

// File: rtl/axi_read_if.sv
// AXI read-channel subset shared by the fetch initiator and the instruction-memory responder.
interface axi_read_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic                  rlast;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rresp, rvalid, rlast
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/ifetch_axi_master.sv
// Turns one line-fetch request into a single AXI read burst and returns the beats as one line.
// One transaction in flight; flush cancels the line but never withdraws or truncates the AXI burst.
module ifetch_axi_master
  import ifetch_axi_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BEATS  = AXI_RMAX_BEATS,
  parameter int LEN_W      = $clog2(MAX_BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_W-1:0]        req_len,
  input  logic                    flush,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [MAX_BEATS*32-1:0] resp_data,
  output logic                    resp_err,
  output logic [1:0]              dbg_state,
  axi_read_if.master              axi_if
);

  localparam int AXLEN_W = 8;
  localparam int CNT_W   = LEN_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // once raised, a valid (and its payload) is held until that edge.
  ifetch_axi_state_t     state;
  logic                  arvalid_q;
  logic                  rready_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [AXLEN_W-1:0]    arlen_q;
  logic [CNT_W-1:0]      beat_cnt;
  logic [AXLEN_W-1:0]    beat_cnt_ext;
  logic                  beat_in_range;
  logic                  cancelled;
  logic [31:0]           line_q [MAX_BEATS];
  logic                  unused_addr_lsbs;

  assign axi_if.araddr  = araddr_q;
  assign axi_if.arlen   = arlen_q;
  assign axi_if.arvalid = arvalid_q;
  assign axi_if.rready  = rready_q;

  assign dbg_state        = state;
  assign beat_cnt_ext     = AXLEN_W'(beat_cnt);
  assign beat_in_range    = (beat_cnt_ext <= arlen_q);
  assign unused_addr_lsbs = ^req_addr[1:0];

  for (genvar g = 0; g < MAX_BEATS; g++) begin : g_line
    assign resp_data[g*32 +: 32] = line_q[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      resp_valid <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      beat_cnt   <= '0;
      resp_err   <= 1'b0;
      cancelled  <= 1'b0;
      for (int i = 0; i < MAX_BEATS; i++) line_q[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            araddr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            arlen_q   <= AXLEN_W'(req_len);
            beat_cnt  <= '0;
            resp_err  <= 1'b0;
            cancelled <= 1'b0;
            for (int i = 0; i < MAX_BEATS; i++) line_q[i] <= '0;
            req_ready <= 1'b0;
            arvalid_q <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (flush) cancelled <= 1'b1;
          if (axi_if.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (flush) cancelled <= 1'b1;
          if (axi_if.rvalid && rready_q) begin
            // Beats past arlen are dropped; the counter saturates so it can never wrap back in range.
            if (beat_in_range) line_q[beat_cnt[LEN_W-1:0]] <= axi_if.rdata;
            else               resp_err <= 1'b1;
            if (axi_if.rresp != AXI_RESP_OKAY) resp_err <= 1'b1;
            if (axi_if.rlast && (beat_cnt_ext != arlen_q)) resp_err <= 1'b1;
            if (beat_cnt != CNT_W'(MAX_BEATS)) beat_cnt <= beat_cnt + 1'b1;
            if (axi_if.rlast) begin
              rready_q <= 1'b0;
              if (cancelled || flush) begin
                cancelled <= 1'b0;
                req_ready <= 1'b1;
                state     <= IDLE;
              end else begin
                resp_valid <= 1'b1;
                state      <= RESP;
              end
            end
          end
        end
        RESP: begin
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_axi_master.sv
// Directed bench for ifetch_axi_master; the bench plays the AXI responder with words = word index.
module tb_ifetch_axi_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [2:0]   req_len;
  logic         flush;
  logic         resp_valid;
  logic         resp_ready;
  logic [255:0] resp_data;
  logic         resp_err;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  axi_read_if #(.ADDR_WIDTH(32)) bus ();

  ifetch_axi_master #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .dbg_state  (dbg_state),
    .axi_if     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks (inputs change on negedge) ----------------
  task automatic send_req(input logic [31:0] addr, input logic [2:0] len, output bit ok);
    int n = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin ok = 1'b0; return; end
    req_valid = 1'b1; req_addr = addr; req_len = len;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic accept_ar(output bit ok, output logic [31:0] a, output logic [7:0] l);
    int n = 0;
    ok = 1'b1; a = '0; l = '0;
    while (!bus.arvalid && n < 20) begin @(negedge clk); n++; end
    if (!bus.arvalid) begin ok = 1'b0; return; end
    a = bus.araddr; l = bus.arlen;
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [1:0] rsp, input logic last, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!bus.rready && n < 20) begin @(negedge clk); n++; end
    if (!bus.rready) begin ok = 1'b0; return; end
    bus.rvalid = 1'b1; bus.rdata = d; bus.rresp = rsp; bus.rlast = last;
    @(negedge clk);
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (bus.arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b want=0", bus.arvalid); end
    total++; if (bus.rready !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b want=0", bus.rready); end
    total++; if (bus.araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr got=%h want=0", bus.araddr); end
    total++; if (bus.arlen !== 8'h0) begin bad++; $display("FAIL reset_arlen got=%h want=0", bus.arlen); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_data !== 256'h0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok; logic [31:0] a; logic [7:0] l;
    send_req(32'h10, 3'd0, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_req_timeout got=0 want=1"); end
    total++; if (bus.arvalid !== 1'b1) begin bad++; $display("FAIL single_arvalid_next got=%b want=1", bus.arvalid); end
    accept_ar(ok, a, l);
    total++; if (!ok || a !== 32'h10 || l !== 8'd0) begin bad++; $display("FAIL single_ar got=%h/%0d want=10/0", a, l); end
    total++; if (bus.rready !== 1'b1) begin bad++; $display("FAIL single_rready got=%b want=1", bus.rready); end
    send_beat(32'h4, 2'b00, 1'b1, ok);
    total++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL single_resp got=%b/%b want=1/0", resp_valid, req_ready); end
    total++; if (resp_data[31:0] !== 32'h4 || resp_err !== 1'b0) begin bad++; $display("FAIL single_data got=%h/%b want=4/0", resp_data[31:0], resp_err); end
    consume();
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL single_done got=%b/%b want=0/1", resp_valid, req_ready); end
  endtask

  task automatic test_burst_hold();
    bit ok; logic [31:0] a; logic [7:0] l; logic [255:0] exp_line;
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = 32'(8 + i);
    send_req(32'h23, 3'd7, ok);
    accept_ar(ok, a, l);
    total++; if (!ok || a !== 32'h20 || l !== 8'd7) begin bad++; $display("FAIL burst_ar got=%h/%0d want=20/7", a, l); end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        total++; if (resp_valid !== 1'b0 || bus.araddr !== 32'h20 || bus.arlen !== 8'd7)
          begin bad++; $display("FAIL burst_pre_last got=%b/%h/%0d want=0/20/7", resp_valid, bus.araddr, bus.arlen); end
      end
      send_beat(32'(8 + i), 2'b00, (i == 7), ok);
    end
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL burst_resp_latency got=%b want=1", resp_valid); end
    total++; if (resp_data !== exp_line || resp_err !== 1'b0) begin bad++; $display("FAIL burst_data got=%h/%b want=%h/0", resp_data, resp_err, exp_line); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== exp_line)
        begin bad++; $display("FAIL burst_hold%0d got=%b/%b want=1/0", k, resp_valid, req_ready); end
    end
    consume();
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL burst_release got=%b/%b want=1/0", req_ready, resp_valid); end
  endtask

  task automatic test_slverr();
    bit ok; logic [31:0] a; logic [7:0] l;
    send_req(32'h40, 3'd3, ok);
    accept_ar(ok, a, l);
    for (int i = 0; i < 4; i++) send_beat(32'(16 + i), (i == 2) ? 2'b10 : 2'b00, (i == 3), ok);
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin bad++; $display("FAIL slverr_flag got=%b/%b want=1/1", resp_valid, resp_err); end
    total++; if (resp_data[127:0] !== {32'd19, 32'd18, 32'd17, 32'd16})
      begin bad++; $display("FAIL slverr_data got=%h want=00000013000000120000001100000010", resp_data[127:0]); end
    consume();
  endtask

  task automatic test_early_last();
    bit ok; logic [31:0] a; logic [7:0] l;
    send_req(32'h0, 3'd3, ok);
    accept_ar(ok, a, l);
    send_beat(32'h0, 2'b00, 1'b0, ok);
    send_beat(32'h1, 2'b00, 1'b1, ok);
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin bad++; $display("FAIL early_last got=%b/%b want=1/1", resp_valid, resp_err); end
    total++; if (resp_data[127:0] !== {64'h0, 32'h1, 32'h0}) begin bad++; $display("FAIL early_last_data got=%h want=100000000", resp_data[127:0]); end
    consume();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL early_last_idle got=%b want=1", req_ready); end
  endtask

  task automatic test_extra_beat();
    bit ok; logic [31:0] a; logic [7:0] l;
    send_req(32'h80, 3'd1, ok);
    accept_ar(ok, a, l);
    send_beat(32'd32, 2'b00, 1'b0, ok);
    send_beat(32'd33, 2'b00, 1'b0, ok);
    total++; if (resp_err !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL extra_pre got=%b/%b want=0/0", resp_err, resp_valid); end
    send_beat(32'hDEADBEEF, 2'b00, 1'b1, ok);
    total++; if (!ok || resp_valid !== 1'b1 || resp_err !== 1'b1) begin bad++; $display("FAIL extra_flag got=%b/%b want=1/1", resp_valid, resp_err); end
    total++; if (resp_data[95:0] !== {32'h0, 32'd33, 32'd32}) begin bad++; $display("FAIL extra_data got=%h want=000000000000002100000020", resp_data[95:0]); end
    consume();
  endtask

  task automatic test_flush();
    bit ok; logic [31:0] a; logic [7:0] l;
    send_req(32'h100, 3'd1, ok);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (bus.arvalid !== 1'b1) begin bad++; $display("FAIL flush_ar_hold got=%b want=1", bus.arvalid); end
    accept_ar(ok, a, l);
    total++; if (!ok || a !== 32'h100 || l !== 8'd1) begin bad++; $display("FAIL flush_ar got=%h/%0d want=100/1", a, l); end
    send_beat(32'd64, 2'b00, 1'b0, ok);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (bus.rready !== 1'b1) begin bad++; $display("FAIL flush_r_drain got=%b want=1", bus.rready); end
    send_beat(32'd65, 2'b00, 1'b1, ok);
    total++; if (!ok || resp_valid !== 1'b0 || req_ready !== 1'b1 || bus.rready !== 1'b0)
      begin bad++; $display("FAIL flush_end got=%b/%b/%b want=0/1/0", resp_valid, req_ready, bus.rready); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_no_resp got=%b want=0", resp_valid); end
    send_req(32'h8, 3'd1, ok);
    accept_ar(ok, a, l);
    send_beat(32'h2, 2'b00, 1'b0, ok);
    send_beat(32'h3, 2'b00, 1'b1, ok);
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data[63:0] !== {32'h3, 32'h2})
      begin bad++; $display("FAIL flush_next got=%b/%b/%h want=1/0/0000000300000002", resp_valid, resp_err, resp_data[63:0]); end
    consume();
    send_req(32'hC, 3'd0, ok);
    accept_ar(ok, a, l);
    send_beat(32'h3, 2'b00, 1'b1, ok);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL flush_resp got=%b/%b want=0/1", resp_valid, req_ready); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_req(32'h44, 3'd2, ok);
    total++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h44) begin bad++; $display("FAIL mid_pre got=%b/%h want=1/44", bus.arvalid, bus.araddr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.arvalid !== 1'b0 || req_ready !== 1'b1 || bus.araddr !== 32'h0 || dbg_state !== 2'd0)
      begin bad++; $display("FAIL mid_reset got=%b/%b/%h/%0d want=0/1/0/0", bus.arvalid, req_ready, bus.araddr, dbg_state); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; flush = 1'b0; resp_ready = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    test_reset();
    test_single();
    test_burst_hold();
    test_slverr();
    test_early_last();
    test_extra_beat();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch_axi_master.md
# ifetch_axi_master

AXI read initiator that turns a single-line fetch request from the instruction-fetch/cache side into one AXI read burst on an `axi_read_if.master` port, then returns the collected beats as one line. It is the initiator matching the instruction-memory responder on the same `axi_read_if`. It handles one outstanding transaction at a time, checks the responses, and supports flushing an in-flight fetch.

## Interface
- MAX_BEATS, 8: maximum beats per burst (8 × 32 bits = 256-bit line).
- LEN_W, 3: width of `req_len`, equal to $clog2(MAX_BEATS).
- clk  in  1  sole clock; everything is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  fetch request.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- req_len  in  LEN_W  number of beats minus 1.
- flush  in  1  single-cycle pulse that cancels the current or pending response.
- resp_valid  out  1  line available.
- resp_ready  in  1  consumer accepts the line.
- resp_data  out  MAX_BEATS*32  beat i is at [i*32 +: 32].
- resp_err  out  1  set if any SLVERR/DECERR response or rlast protocol error occurred.
- axi_if  axi_read_if.master  uses araddr, arlen, arvalid, arready, rdata, rresp, rvalid, rready, rlast.

## Operation
- States: IDLE, AR, R, RESP. Reset goes to IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`:
    - latch araddr = {req_addr[ADDR_WIDTH-1:2], 2'b00} and arlen = zero-extended req_len;
    - clear resp_data, resp_err and the beat counter;
    - go to AR.
- **AR**
  - arvalid=1.
  - araddr and arlen stay stable until arvalid && arready.
  - Then go to R.
- **R**
  - rready=1.
  - On each rvalid && rready, write rdata to slot `beat_cnt` if beat_cnt ≤ arlen, then increment beat_cnt.
  - Beats beyond arlen are discarded and set resp_err.
  - rresp ≠ AXI_RESP_OKAY sets resp_err (sticky).
  - rlast on a beat with beat_cnt ≠ arlen sets resp_err.
  - rlast ends the burst and moves to RESP, or to IDLE if the transaction is cancelled.
- **RESP**
  - resp_valid=1.
  - Holds until resp_ready, then goes to IDLE.
- araddr and arlen are held unchanged from acceptance until leaving R, because the responder samples arlen during its data phase.
- **flush**
  - In IDLE: no effect. A request in the same cycle is still accepted.
  - In AR: arvalid stays asserted until the handshake; the AXI transaction is never withdrawn. The transaction is marked cancelled.
  - In R: marked cancelled. The remaining beats are still drained until rlast, then the state goes to IDLE with no resp_valid.
  - In RESP: resp_valid drops the next cycle and the state goes to IDLE. The line is dropped.
- The cancelled flag clears on entry to IDLE.
- **rst** mid-operation: state and outputs return to reset values the next cycle. No drain is performed; the system resets the responder with the same reset.
- Reset values: req_ready=1 (IDLE), arvalid=0, rready=0, araddr=0, arlen=0, resp_valid=0, resp_data=0, resp_err=0.

## Timing
- Request accepted in cycle N → arvalid=1 in cycle N+1.
- AR handshake in cycle M → rready=1 from cycle M+1.
- rlast beat in cycle K → resp_valid=1 in cycle K+1. With resp_ready held high, req_ready=1 in K+2.
- Latency without stalls: 3 cycles plus the responder delay plus beats.
- arvalid, rready and resp_valid are registered outputs decoded from state.
- req_ready and resp_valid are never high in the same cycle.

## Structure
- Add to `_pkg_riscv_defines`:
  - constant AXI_RMAX_BEATS=8;
  - enum `ifetch_axi_state_t` {IDLE, AR, R, RESP};
  - reuse the existing AXI_RESP_* codes.
- Single module, about 200 lines. No sub-module; the beat buffer is an indexed register array inside the module.

## Test plan
- Request addr 0x0000_0010, len 0, against the memory model (words = index) → one AR with araddr=0x10, arlen=0. resp_data[31:0]=0x4, resp_err=0.
- Request addr 0x23, len 7 → araddr=0x20, arlen=7. Eight beats 0x8..0xF land in slots 0..7. resp_valid arrives exactly 1 cycle after the rlast beat.
- Hold resp_ready=0 for 5 cycles after resp_valid → resp_valid and resp_data stay stable and req_ready=0. req_ready=1 the cycle after resp_ready.
- Responder returns SLVERR on beat 2 of 4 → resp_err=1 and all 4 beats are still stored.
- Early rlast on beat 1 with len=3 → resp_err=1 and the state returns via RESP. Extra beat without rlast → data discarded, resp_err=1.
- Pulse flush during AR wait, then during R → burst drains to rlast, no resp_valid. The next request is accepted and completes normally.
